// File: rtl/seq_pkg.sv
// Shared state/class encodings, opcode and funct values, and PC source selects
// for the multicycle sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_R,
    ALU_I,
    LOAD,
    STORE,
    BRANCH,
    JUMP,
    JUMP_REG
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG    = 2'b11;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// RAM handshake between the sequencer (master) and the shared single-port RAM (slave).
interface multicycle_sequencer_if;
  logic ram_ready;
  logic ram_read_enable;
  logic ram_write_enable;
  logic mem_addr_sel;

  modport master (
    input  ram_ready,
    output ram_read_enable,
    output ram_write_enable,
    output mem_addr_sel
  );

  modport slave (
    output ram_ready,
    input  ram_read_enable,
    input  ram_write_enable,
    input  mem_addr_sel
  );
endinterface

// File: rtl/instr_classifier.sv
// Combinational opcode/funct decode into an instruction class, a link flag
// (JAL/JALR) and an illegal-opcode flag.
module instr_classifier
  import seq_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t instr_class,
  output logic         link,
  output logic         illegal
);

  always_comb begin
    instr_class = ALU_R;
    link        = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          instr_class = JUMP_REG;
        end else if (funct == FN_JALR) begin
          instr_class = JUMP_REG;
          link        = 1'b1;
        end
      end
      OP_J:   instr_class = JUMP;
      OP_JAL: begin
        instr_class = JUMP;
        link        = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: instr_class = BRANCH;
      OP_LB, OP_LW:                     instr_class = LOAD;
      OP_SB, OP_SW:                     instr_class = STORE;
      default: begin
        if (opcode >= OP_ADDI && opcode <= OP_LUI) instr_class = ALU_I;
        else                                       illegal     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control sequencer.
// Define SEQ_PERF_COUNTERS_EN to add cycle_count/instr_count outputs.
module multicycle_sequencer
  import seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [31:0]            instruction,
  input  logic                   branch_taken,
  multicycle_sequencer_if.master ram,
  output logic [2:0]             state,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic [1:0]             pc_src,
  output logic                   alu_src,
  output logic                   reg_write_enable,
  output logic                   mem_to_reg,
  output logic                   link,
  output logic                   retired,
  output logic                   trap
`ifdef SEQ_PERF_COUNTERS_EN
  ,
  output logic [31:0]            cycle_count,
  output logic [31:0]            instr_count
`endif
);

  state_t       state_q;
  state_t       state_d;
  instr_class_t cls_q;
  instr_class_t cls_dec;
  logic         link_q;
  logic         link_dec;
  logic         illegal_dec;
  logic         fetch_pending_q;
  logic         store_retire_q;
  logic         fetch_active;
  logic         unused_instr_bits;

  assign unused_instr_bits = ^instruction[25:6];

  instr_classifier u_classifier (
    .opcode      (instruction[31:26]),
    .funct       (instruction[5:0]),
    .instr_class (cls_dec),
    .link        (link_dec),
    .illegal     (illegal_dec)
  );

  // A started fetch keeps its read asserted even if run drops while RAM stalls.
  assign fetch_active = (state_q == FETCH) && reset && (run || fetch_pending_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= FETCH;
      cls_q           <= ALU_R;
      link_q          <= 1'b0;
      fetch_pending_q <= 1'b0;
      store_retire_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetch_pending_q <= fetch_active && !ram.ram_ready;
      store_retire_q  <= (state_q == MEMORY) && (cls_q == STORE) && ram.ram_ready;
      if (state_q == DECODE) begin
        cls_q  <= cls_dec;
        link_q <= link_dec;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     if (fetch_active && ram.ram_ready) state_d = DECODE;
      DECODE:    state_d = illegal_dec ? TRAP : EXECUTE;
      EXECUTE: begin
        case (cls_q)
          ALU_R, ALU_I: state_d = WRITEBACK;
          LOAD, STORE:  state_d = MEMORY;
          default:      state_d = FETCH;
        endcase
      end
      MEMORY: begin
        if (ram.ram_ready) state_d = (cls_q == LOAD) ? WRITEBACK : FETCH;
      end
      WRITEBACK: state_d = FETCH;
      TRAP:      state_d = TRAP;
      default:   state_d = FETCH;
    endcase
  end

  // A store retires the cycle after its write completes, never alongside the write strobe.
  always_comb begin
    ram.ram_read_enable  = 1'b0;
    ram.ram_write_enable = 1'b0;
    ram.mem_addr_sel     = 1'b0;
    ir_write             = 1'b0;
    pc_write             = 1'b0;
    pc_src               = PC_SRC_SEQ;
    alu_src              = 1'b0;
    reg_write_enable     = 1'b0;
    mem_to_reg           = 1'b0;
    link                 = 1'b0;
    retired              = store_retire_q;
    trap                 = 1'b0;
    case (state_q)
      FETCH: begin
        ram.ram_read_enable = fetch_active;
        ir_write            = fetch_active && ram.ram_ready;
        pc_write            = fetch_active && ram.ram_ready;
      end
      EXECUTE: begin
        case (cls_q)
          ALU_I, LOAD, STORE: alu_src = 1'b1;
          BRANCH: begin
            pc_write = branch_taken;
            pc_src   = PC_SRC_BRANCH;
            retired  = 1'b1;
          end
          JUMP: begin
            pc_write         = 1'b1;
            pc_src           = PC_SRC_JUMP;
            retired          = 1'b1;
            reg_write_enable = link_q;
            link             = link_q;
          end
          JUMP_REG: begin
            pc_write         = 1'b1;
            pc_src           = PC_SRC_REG;
            retired          = 1'b1;
            reg_write_enable = link_q;
            link             = link_q;
          end
          default: ;
        endcase
      end
      MEMORY: begin
        ram.mem_addr_sel     = 1'b1;
        ram.ram_read_enable  = (cls_q == LOAD);
        ram.ram_write_enable = (cls_q == STORE);
      end
      WRITEBACK: begin
        reg_write_enable = 1'b1;
        mem_to_reg       = (cls_q == LOAD);
        retired          = 1'b1;
      end
      TRAP:    trap = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

`ifdef SEQ_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= 32'd0;
      instr_count <= 32'd0;
    end else begin
      if (state_q != TRAP && (run || state_q != FETCH)) cycle_count <= cycle_count + 32'd1;
      if (retired) instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: each instruction pushes its per-cycle
// stimulus and expected outputs, which are popped and compared cycle by cycle.
module tb_multicycle_sequencer;

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
                         S_MEMORY = 3'd3, S_WRITEBACK = 3'd4, S_TRAP = 3'd5;

  typedef struct packed {
    logic [2:0] st;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       mem_addr_sel;
    logic       rd;
    logic       wr;
    logic       alu_src;
    logic       rwe;
    logic       m2r;
    logic       link;
    logic       retired;
    logic       trap;
  } out_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        run;
    logic        ready;
    logic        taken;
  } stim_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [31:0] instruction;
  logic        branch_taken;
  logic [2:0]  state;
  logic        ir_write, pc_write, alu_src, reg_write_enable, mem_to_reg, link, retired, trap;
  logic [1:0]  pc_src;

  multicycle_sequencer_if ram_bus ();

  multicycle_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .run              (run),
    .instruction      (instruction),
    .branch_taken     (branch_taken),
    .ram              (ram_bus),
    .state            (state),
    .ir_write         (ir_write),
    .pc_write         (pc_write),
    .pc_src           (pc_src),
    .alu_src          (alu_src),
    .reg_write_enable (reg_write_enable),
    .mem_to_reg       (mem_to_reg),
    .link             (link),
    .retired          (retired),
    .trap             (trap)
  );

  always #5 clk = ~clk;

  stim_t stim_q[$];
  out_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    passed = 0;
  bit    store_retire_due = 1'b0;

  task automatic check_output(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  function automatic out_t observe();
    out_t o;
    o.st           = state;
    o.ir_write     = ir_write;
    o.pc_write     = pc_write;
    o.pc_src       = pc_src;
    o.mem_addr_sel = ram_bus.mem_addr_sel;
    o.rd           = ram_bus.ram_read_enable;
    o.wr           = ram_bus.ram_write_enable;
    o.alu_src      = alu_src;
    o.rwe          = reg_write_enable;
    o.m2r          = mem_to_reg;
    o.link         = link;
    o.retired      = retired;
    o.trap         = trap;
    return o;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push_cycle(string tag, logic [31:0] instr, logic r, logic rdy,
                                     logic tk, out_t e);
    stim_t s;
    s.instr = instr;
    s.run   = r;
    s.ready = rdy;
    s.taken = tk;
    if (store_retire_due) begin
      e.retired        = 1'b1;
      store_retire_due = 1'b0;
    end
    stim_q.push_back(s);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endfunction

  function automatic void push_idle(int n);
    out_t e;
    for (int i = 0; i < n; i++) begin
      e    = '0;
      e.st = S_FETCH;
      push_cycle("idle", 32'h0, 1'b0, rnd(), rnd(), e);
    end
  endfunction

  task automatic apply_stimulus(string name, logic [31:0] instr, int fetch_stalls,
                                int mem_stalls, logic taken, bit abort_in_mem);
    out_t       e;
    logic [5:0] op;
    logic [5:0] fn;
    bit is_r, is_jr, is_jalr, is_j, is_jal, is_br, is_alui, is_ld, is_st, legal;
    op      = instr[31:26];
    fn      = instr[5:0];
    is_jr   = (op == 6'd0) && (fn == 6'h08);
    is_jalr = (op == 6'd0) && (fn == 6'h09);
    is_r    = (op == 6'd0) && !is_jr && !is_jalr;
    is_j    = (op == 6'd2);
    is_jal  = (op == 6'd3);
    is_br   = (op >= 6'd4) && (op <= 6'd7);
    is_alui = (op >= 6'd8) && (op <= 6'd15);
    is_ld   = (op == 6'h20) || (op == 6'h23);
    is_st   = (op == 6'h28) || (op == 6'h2B);
    legal   = is_r || is_jr || is_jalr || is_j || is_jal || is_br || is_alui || is_ld || is_st;

    for (int i = 0; i <= fetch_stalls; i++) begin
      e    = '0;
      e.st = S_FETCH;
      e.rd = 1'b1;
      if (i == fetch_stalls) begin
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
      end
      push_cycle({name, "/fetch"}, instr, 1'b1, (i == fetch_stalls), rnd(), e);
    end

    e    = '0;
    e.st = S_DECODE;
    push_cycle({name, "/decode"}, instr, rnd(), rnd(), rnd(), e);

    if (!legal) begin
      for (int i = 0; i < 4; i++) begin
        e      = '0;
        e.st   = S_TRAP;
        e.trap = 1'b1;
        push_cycle({name, "/trap"}, instr, 1'b1, rnd(), rnd(), e);
      end
      return;
    end

    e         = '0;
    e.st      = S_EXECUTE;
    e.alu_src = is_alui || is_ld || is_st;
    if (is_br) begin
      e.pc_write = taken;
      e.pc_src   = 2'b01;
      e.retired  = 1'b1;
    end
    if (is_j || is_jal || is_jr || is_jalr) begin
      e.pc_write = 1'b1;
      e.pc_src   = (is_jr || is_jalr) ? 2'b11 : 2'b10;
      e.retired  = 1'b1;
      e.rwe      = is_jal || is_jalr;
      e.link     = is_jal || is_jalr;
    end
    push_cycle({name, "/execute"}, instr, rnd(), rnd(), taken, e);

    if (is_ld || is_st) begin
      for (int i = 0; i <= mem_stalls; i++) begin
        e              = '0;
        e.st           = S_MEMORY;
        e.mem_addr_sel = 1'b1;
        e.rd           = is_ld;
        e.wr           = is_st;
        push_cycle({name, "/memory"}, instr, rnd(), (i == mem_stalls), rnd(), e);
        if (abort_in_mem) return;
      end
      if (is_st) store_retire_due = 1'b1;
    end

    if (is_ld || is_r || is_alui) begin
      e         = '0;
      e.st      = S_WRITEBACK;
      e.rwe     = 1'b1;
      e.m2r     = is_ld;
      e.retired = 1'b1;
      push_cycle({name, "/writeback"}, instr, rnd(), rnd(), rnd(), e);
    end
  endtask

  task automatic run_queue();
    stim_t s;
    out_t  e;
    string t;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      @(posedge clk);
      #1;
      instruction       = s.instr;
      run               = s.run;
      ram_bus.ram_ready = s.ready;
      branch_taken      = s.taken;
      @(negedge clk);
      check_output(t, 32'(observe()), 32'(e));
    end
  endtask

  task automatic release_reset();
    run = 1'b0;
    @(posedge clk);
    #2;
    reset            = 1'b0;
    reset            = 1'b1;
    store_retire_due = 1'b0;
  endtask

  initial begin
    reset             = 1'b0;
    run               = 1'b1;
    instruction       = 32'h0;
    branch_taken      = 1'b0;
    ram_bus.ram_ready = 1'b1;
    #1;
    check_output("reset/outputs", 32'(observe()), 32'(0));
    run = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    push_idle(2);
    apply_stimulus("add",      32'h00002020, 0, 0, 1'b0, 1'b0);
    apply_stimulus("lw_stall", 32'h8C040001, 0, 2, 1'b0, 1'b0);
    apply_stimulus("beq_nt",   32'h10220000, 0, 0, 1'b0, 1'b0);
    apply_stimulus("beq_t",    32'h10220000, 0, 0, 1'b1, 1'b0);
    apply_stimulus("jal",      32'h0C000000, 0, 0, 1'b0, 1'b0);
    push_idle(2);
    apply_stimulus("addi_fst", 32'h20010005, 1, 0, 1'b0, 1'b0);
    apply_stimulus("sw_stall", 32'hAC010004, 0, 1, 1'b0, 1'b0);
    push_idle(2);
    apply_stimulus("lb",       32'h80010000, 0, 0, 1'b0, 1'b0);
    apply_stimulus("sb",       32'hA0010000, 0, 0, 1'b0, 1'b0);
    apply_stimulus("j",        32'h08000000, 0, 0, 1'b0, 1'b0);
    apply_stimulus("jr",       32'h03E00008, 0, 0, 1'b0, 1'b0);
    apply_stimulus("jalr",     32'h0040F809, 0, 0, 1'b0, 1'b0);
    apply_stimulus("lw_fst",   32'h8C040001, 2, 0, 1'b0, 1'b0);
    run_queue();

    // Store held in MEMORY by a RAM stall, then reset lands mid-access.
    apply_stimulus("sw_rst",   32'hAC010004, 0, 3, 1'b0, 1'b1);
    run_queue();
    #1;
    check_output("sw_rst/wr_before", 32'(ram_bus.ram_write_enable), 32'(1));
    reset = 1'b0;
    #1;
    check_output("sw_rst/wr_async", 32'(ram_bus.ram_write_enable), 32'(0));
    check_output("sw_rst/state", 32'(state), 32'(S_FETCH));
    release_reset();
    push_idle(2);
    run_queue();

    apply_stimulus("illegal",  32'hFC000000, 0, 0, 1'b0, 1'b0);
    run_queue();
    #1;
    reset = 1'b0;
    #1;
    check_output("trap_rst/trap", 32'(trap), 32'(0));
    check_output("trap_rst/state", 32'(state), 32'(S_FETCH));
    release_reset();
    push_idle(1);
    apply_stimulus("add_after", 32'h00002020, 0, 0, 1'b0, 1'b0);
    push_idle(1);
    run_queue();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
